// File: rtl/if_prefetch_queue_if.sv
// Bundles the fetch-side handshake signals of the instruction prefetch queue:
// imem request/response, redirect from EX, and the queue head toward IF/ID.
// The master modport is the prefetch queue; slave is its environment.
interface if_prefetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instruction;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instruction, id_pc, id_pc_plus_4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instruction, id_pc, id_pc_plus_4,
    output id_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit rule so
// every outstanding response has a queue slot, buffers {instr, pc} entries for
// IF/ID and squashes everything in flight on a redirect.
// Optional: define IF_PREFETCH_PERF_EN to add perf_fetched / perf_squashed.
module if_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  if_prefetch_queue_if.master bus
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_squashed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {StInit, StFetch, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_d;
  // pc of the next non-stale response; advances per push
  logic [XLEN-1:0] r_rsp_pc, w_rsp_pc_d;
  logic [CW-1:0]   r_outstanding, w_outstanding_d;
  logic [CW-1:0]   r_discard, w_discard_d;
  logic [CW-1:0]   r_count, w_count_d;
  logic [PW-1:0]   r_wptr, w_wptr_d;
  logic [PW-1:0]   r_rptr, w_rptr_d;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_pc;
  logic [CW:0]     w_inflight;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_push;
  logic            w_stale_rsp;
  logic            w_id_valid;
  logic            w_pop;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid   = (r_state == StFetch) && !w_redirect && (w_inflight < DEPTH_L);
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;
  assign w_stale_rsp   = bus.imem_rsp_valid && (w_redirect || (r_discard != '0));
  assign w_push        = bus.imem_rsp_valid && !w_redirect && (r_discard == '0);
  assign w_id_valid    = (r_count != '0) && !w_redirect;
  assign w_pop         = w_id_valid && bus.id_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_instruction = r_mem_instr[r_rptr];
  assign bus.id_pc          = r_mem_pc[r_rptr];
  assign bus.id_pc_plus_4   = r_mem_pc[r_rptr] + XLEN'(4);

  // Next-state: redirect wins over push/pop and turns all in-flight into stale.
  always_comb begin
    w_state_d       = r_state;
    w_fetch_pc_d    = r_fetch_pc;
    w_rsp_pc_d      = r_rsp_pc;
    w_outstanding_d = r_outstanding + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);
    w_discard_d     = r_discard;
    w_count_d       = r_count;
    w_wptr_d        = r_wptr;
    w_rptr_d        = r_rptr;

    if (w_redirect) begin
      w_fetch_pc_d = w_redirect_pc;
      w_rsp_pc_d   = w_redirect_pc;
      // no request fires in a redirect cycle, so this is what remains in flight
      w_discard_d  = r_outstanding - CW'(bus.imem_rsp_valid);
      w_count_d    = '0;
      w_wptr_d     = '0;
      w_rptr_d     = '0;
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_d = r_fetch_pc + XLEN'(4);
      end
      if (w_stale_rsp) begin
        w_discard_d = r_discard - CW'(1);
      end
      if (w_push) begin
        w_rsp_pc_d = r_rsp_pc + XLEN'(4);
        w_wptr_d   = r_wptr + PW'(1);
      end
      if (w_pop) begin
        w_rptr_d = r_rptr + PW'(1);
      end
      w_count_d = r_count + CW'(w_push) - CW'(w_pop);
    end

    unique case (r_state)
      StInit:  w_state_d = StFetch;
      StFetch: w_state_d = (w_redirect && (w_discard_d != '0)) ? StDrain : StFetch;
      StDrain: w_state_d = (w_discard_d == '0) ? StFetch : StDrain;
      default: w_state_d = StInit;
    endcase
  end

  // Control state, pcs and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StInit;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_state       <= w_state_d;
      r_fetch_pc    <= w_fetch_pc_d;
      r_rsp_pc      <= w_rsp_pc_d;
      r_outstanding <= w_outstanding_d;
      r_discard     <= w_discard_d;
      r_count       <= w_count_d;
      r_wptr        <= w_wptr_d;
      r_rptr        <= w_rptr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wptr]    <= r_rsp_pc;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;

  // Pushes, and flushed entries plus dropped responses; both wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_redirect) begin
        r_perf_squashed <= r_perf_squashed + 32'(r_count) + 32'(bus.imem_rsp_valid);
      end else if (w_stale_rsp) begin
        r_perf_squashed <= r_perf_squashed + 32'd1;
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue. The reference model treats the
// design as "deliver the sequential instruction stream, restarting at each
// redirect target" plus an in-order imem with random latency.
module tb_if_prefetch_queue;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.XLEN(XLEN)) bus ();

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  if_prefetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          drv_req_ready = 1'b0;
  bit          drv_id_ready = 1'b0;
  logic [31:0] exp_req_addr;
  logic [31:0] exp_id_pc;
  int unsigned exp_fetched;
  int unsigned exp_squashed;
  int unsigned pops_total;
  int          n_req;
  int          n_pop;
  bit          last_req_valid;
  logic [31:0] last_req_addr;
  bit          last_id_valid;
  bit          last_rsp;
  logic [31:0] first_pop_pc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  // One cycle: drive after negedge, sample 1 time unit later, update the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit          rsp = 1'b0;
    bit          rsp_stale = 1'b0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] tgt;
    int          lat;
    int          due;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp       = 1'b1;
      rsp_addr  = pend[0].addr;
      rsp_stale = pend[0].stale;
      void'(pend.pop_front());
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(rsp_addr);
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = drv_req_ready;
    bus.id_ready       = drv_id_ready;
    #1;
    last_rsp       = rsp;
    last_req_valid = bus.imem_req_valid;
    last_req_addr  = bus.imem_req_addr;
    last_id_valid  = bus.id_valid;
    if (redir) begin
      check_eq("redir_id_valid", {63'd0, bus.id_valid}, 64'd0);
      check_eq("redir_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check_eq("req_addr", {32'd0, bus.imem_req_addr}, {32'd0, exp_req_addr});
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: bus.imem_req_addr, due: due, stale: 1'b0});
      exp_req_addr += 32'd4;
      n_req++;
    end
    if (bus.id_valid && bus.id_ready) begin
      check_eq("id_pc", {32'd0, bus.id_pc}, {32'd0, exp_id_pc});
      check_eq("id_instr", {32'd0, bus.id_instruction}, {32'd0, mem_word(exp_id_pc)});
      check_eq("id_pc4", {32'd0, bus.id_pc_plus_4}, {32'd0, exp_id_pc + 32'd4});
      if (n_pop == 0) first_pop_pc = bus.id_pc;
      exp_id_pc += 32'd4;
      n_pop++;
      pops_total++;
    end
    if (redir) begin
      tgt = {rpc[31:2], 2'b00};
      exp_squashed += (exp_fetched - pops_total) + 32'(rsp);
      // queue contents are gone; count them as already consumed
      pops_total = exp_fetched;
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_req_addr = tgt;
      exp_id_pc    = tgt;
    end else if (rsp) begin
      if (rsp_stale) exp_squashed++;
      else exp_fetched++;
    end
    if (pend.size() > DEPTH) check_eq("credit", pend.size(), DEPTH);
    @(posedge clk);
    cyc++;
  endtask

  task automatic check_perf(input string tag);
    #1;
`ifdef IF_PREFETCH_PERF_EN
    check_eq({tag, "_perf_fetched"}, {32'd0, perf_fetched}, {32'd0, exp_fetched});
    check_eq({tag, "_perf_squashed"}, {32'd0, perf_squashed}, {32'd0, exp_squashed});
`else
    check_eq({tag, "_credit"}, {63'd0, pend.size() <= DEPTH}, 64'd1);
`endif
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq({tag, "_rst_req_valid"}, {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq({tag, "_rst_id_valid"}, {63'd0, bus.id_valid}, 64'd0);
    check_eq({tag, "_rst_id_instr"}, {32'd0, bus.id_instruction}, 64'd0);
    check_eq({tag, "_rst_id_pc"}, {32'd0, bus.id_pc}, 64'd0);
`ifdef IF_PREFETCH_PERF_EN
    check_eq({tag, "_rst_perf_f"}, {32'd0, perf_fetched}, 64'd0);
    check_eq({tag, "_rst_perf_s"}, {32'd0, perf_squashed}, 64'd0);
`endif
    pend.delete();
    exp_req_addr = RESET_PC;
    exp_id_pc    = RESET_PC;
    exp_fetched  = 0;
    exp_squashed = 0;
    pops_total   = 0;
    n_req        = 0;
    n_pop        = 0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int first;
    int drain;
    reset = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Streaming with 1-cycle latency: first id_valid three cycles after release.
    do_reset("a");
    drv_req_ready = 1'b1;
    drv_id_ready  = 1'b1;
    lat_min = 1;
    lat_max = 1;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, '0);
      if (i == 1) begin
        check_eq("a_first_req_valid", {63'd0, last_req_valid}, 64'd1);
        check_eq("a_first_req_addr", {32'd0, last_req_addr}, {32'd0, RESET_PC});
      end
      if (last_id_valid && first < 0) first = i;
    end
    check_eq("a_first_id_valid", first, 3);
    check_eq("a_throughput", {63'd0, n_pop >= 30}, 64'd1);
    check_perf("a");

    // Back-pressure: DEPTH requests then stall, nothing lost afterwards.
    do_reset("b");
    drv_id_ready = 1'b0;
    repeat (20) step(1'b0, '0);
    check_eq("b_req_count", n_req, DEPTH);
    check_eq("b_req_stalled", {63'd0, last_req_valid}, 64'd0);
    check_eq("b_queue_full_valid", {63'd0, last_id_valid}, 64'd1);
    check_perf("b");
    drv_id_ready = 1'b1;
    n_pop = 0;
    repeat (12) step(1'b0, '0);
    check_eq("b_drained", {63'd0, n_pop >= 4}, 64'd1);
    check_eq("b_first_pop", {32'd0, first_pop_pc}, {32'd0, RESET_PC});

    // Redirect with two stale responses of 3-cycle latency.
    do_reset("c");
    lat_min = 3;
    lat_max = 3;
    drv_req_ready = 1'b1;
    drv_id_ready  = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    drv_req_ready = 1'b0;
    check_eq("c_outstanding", pend.size(), 2);
    step(1'b1, 32'h0000_0100);
    drv_req_ready = 1'b1;
    drain = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0);
      if (last_req_valid) break;
      drain++;
    end
    check_eq("c_drain_len", {63'd0, drain >= 2 && drain <= 3}, 64'd1);
    check_eq("c_restart_addr", {32'd0, last_req_addr}, 64'h100);
    n_pop = 0;
    repeat (12) step(1'b0, '0);
    check_eq("c_popped", {63'd0, n_pop > 0}, 64'd1);
    check_eq("c_first_pop_pc", {32'd0, first_pop_pc}, 64'h100);
    check_perf("c");

    // Misaligned redirect target is forced to a word boundary.
    do_reset("d");
    lat_min = 1;
    lat_max = 1;
    drv_req_ready = 1'b0;
    step(1'b0, '0);
    step(1'b1, 32'h0000_0203);
    drv_req_ready = 1'b1;
    step(1'b0, '0);
    check_eq("d_req_valid", {63'd0, last_req_valid}, 64'd1);
    check_eq("d_aligned_addr", {32'd0, last_req_addr}, 64'h200);

    // Redirect colliding with a response and a would-be id handshake.
    do_reset("e");
    drv_req_ready = 1'b1;
    drv_id_ready  = 1'b1;
    repeat (10) step(1'b0, '0);
    check_eq("e_rsp_due", {63'd0, pend.size() > 0 && pend[0].due <= cyc}, 64'd1);
    n_pop = 0;
    step(1'b1, 32'h0000_0400);
    check_eq("e_rsp_arrived", {63'd0, last_rsp}, 64'd1);
    check_eq("e_no_pop", n_pop, 0);
    step(1'b0, '0);
    check_eq("e_queue_empty", {63'd0, last_id_valid}, 64'd0);
    check_eq("e_restart_addr", {32'd0, last_req_addr}, 64'h400);
    repeat (6) step(1'b0, '0);
    check_perf("e");

    // Reset with the queue full: everything clears and fetch restarts.
    do_reset("f");
    drv_id_ready = 1'b0;
    repeat (12) step(1'b0, '0);
    check_perf("f_full");
    do_reset("f2");
    drv_id_ready = 1'b1;
    step(1'b0, '0);
    check_eq("f_restart_addr", {32'd0, last_req_addr}, {32'd0, RESET_PC});
    repeat (8) step(1'b0, '0);
    check_eq("f_first_pop", {32'd0, first_pop_pc}, {32'd0, RESET_PC});

    // Random traffic: ready, latency and redirects all vary.
    do_reset("g");
    lat_min = 1;
    lat_max = 4;
    n_pop = 0;
    for (int i = 0; i < 600; i++) begin
      drv_req_ready = ($urandom_range(3, 0) != 0);
      drv_id_ready  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) step(1'b1, $urandom & 32'h0000_FFFF);
      else step(1'b0, '0);
    end
    check_eq("g_progress", {63'd0, n_pop > 50}, 64'd1);
    check_perf("g");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output XLEN  fetch request channel.
REQ-007 SHALL have ports imem_rsp_valid input 1, imem_rsp_data input 32  in-order responses, one per accepted request, latency >=1 cycle.
REQ-008 SHALL have ports redirect_valid input 1, redirect_pc input XLEN  taken branch/jump from EX.
REQ-009 SHALL have ports id_valid output 1, id_ready input 1, id_instruction output 32, id_pc output XLEN, id_pc_plus_4 output XLEN  queue head to IF/ID.

Function
REQ-010 SHALL hold fetch_pc, outstanding count, discard count, DEPTH-entry queue {instr, pc} with wrapping read/write pointers and occupancy count.
REQ-011 SHALL assert imem_req_valid only in FETCH, redirect_valid low, occupancy+outstanding < DEPTH; imem_req_addr = fetch_pc.
REQ-012 SHALL on request accept (valid&&ready) increment outstanding and fetch_pc by 4, modulo 2^XLEN.
REQ-013 SHALL write each non-discarded response into queue tail with its pc; entry visible on id_valid the following cycle (no bypass).
REQ-014 SHALL drive id_valid = (occupancy>0) && !redirect_valid; pop head on id_valid&&id_ready; id_pc_plus_4 = id_pc+4.
REQ-015 SHALL support push and pop in the same cycle with occupancy unchanged.
REQ-016 SHALL never overflow: credit rule of REQ-011 guarantees a slot for every outstanding response.
REQ-017 SHALL on redirect_valid: clear queue, set fetch_pc = {redirect_pc[XLEN-1:2],2'b00}, mark all outstanding responses (including one arriving that cycle) as stale via discard count.
REQ-018 SHALL implement FSM states INIT, FETCH, DRAIN.
REQ-019 SHALL transition INIT->FETCH unconditionally one cycle after reset release.
REQ-020 SHALL transition FETCH->DRAIN on redirect with stale responses still pending after that cycle, else remain FETCH.
REQ-021 SHALL in DRAIN issue no requests, drop each response decrementing discard count, return to FETCH in the cycle the last stale response arrives.
REQ-022 SHALL in DRAIN accept further redirects by updating fetch_pc only.
REQ-023 SHALL give redirect priority over pop and push in the same cycle; id handshake in a redirect cycle does not occur.

Reset
REQ-024 SHALL on reset low asynchronously set: state INIT, fetch_pc RESET_PC, occupancy/outstanding/discard 0, pointers 0, imem_req_valid 0, id_valid 0, id_instruction 0, id_pc 0.
REQ-025 SHALL assume imem shares reset; reset mid-operation abandons all in-flight requests.

Configuration
REQ-026 SHALL, with IF_PREFETCH_PERF_EN defined, add outputs perf_fetched (32) counting queue pushes and perf_squashed (32) counting flushed entries plus discarded responses; both reset to 0, wrap at 2^32.
REQ-027 SHALL, without IF_PREFETCH_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-028 SHALL test: reset release, imem_req_ready=1, 1-cycle latency, id_ready=1 -> addresses 0,4,8,... in order, first id_valid 3 cycles after release.
REQ-029 SHALL test: id_ready=0, DEPTH=4 -> exactly 4 requests issued then imem_req_valid stays 0; occupancy 4; no data lost after id_ready=1.
REQ-030 SHALL test: redirect to 0x100 with 2 outstanding, 3-cycle latency -> both stale responses dropped, DRAIN 2-3 cycles, next id_pc 0x100.
REQ-031 SHALL test: redirect_pc=0x203 -> next imem_req_addr 0x200.
REQ-032 SHALL test: redirect in same cycle as response arrival and id handshake -> no pop counted, response dropped, queue empty next cycle.
REQ-033 SHALL test: reset asserted with queue full and IF_PREFETCH_PERF_EN defined -> all outputs and counters 0, fetch restarts at RESET_PC.
